// File: rtl/uart_pkg.sv
// Shared UART receive-path types: shift-register operation codes and default packet width.
package uart_pkg;

    typedef enum logic [1:0] {
        SH_HOLD   = 2'd0,
        SH_SERIAL = 2'd1,
        SH_LOAD   = 2'd2,
        SH_CLEAR  = 2'd3
    } shift_op_t;

    localparam int PACKET_SIZE = 4;

endpackage

// File: rtl/packet_bit_counter.sv
// Counts serial shifts and emits a registered one-cycle wrap pulse when a packet completes.
module packet_bit_counter #(
    parameter int packetSize = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inc,
    input  logic                             clr,
    output logic                             wrap,
    output logic [$clog2(packetSize+1)-1:0]  count
);

    localparam int CW = $clog2(packetSize + 1);
    localparam logic [CW-1:0] LAST = CW'(packetSize - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            // wrap only ever follows the shift that completes a packet
            wrap <= inc && (count == LAST);
            if (clr)
                count <= '0;
            else if (inc)
                count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/bit_stream_reg.sv
// Receive-side serial-to-parallel register with hold, parallel load, clear and packet-complete pulse.
module bit_stream_reg
    import uart_pkg::*;
#(
    parameter int packetSize = PACKET_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  LD,
    input  logic                  msbLD,
    input  logic [1:0]            shift,
    input  logic [packetSize-1:0] dIn,
    output logic [packetSize-1:0] dOut,
    output logic                  SIGNALGOT
);

    localparam int CW = $clog2(packetSize + 1);

    shift_op_t     op;
    logic          inc;
    logic          clr;
    logic [CW-1:0] count;

    assign op  = shift_op_t'(shift);
    assign inc = LD && (op == SH_SERIAL);
    assign clr = LD && ((op == SH_LOAD) || (op == SH_CLEAR));

    always_ff @(posedge clk) begin
        if (reset) begin
            dOut <= '0;
        end else if (LD) begin
            case (op)
                SH_SERIAL: begin
                    if (msbLD)
                        dOut <= {dIn[0], dOut[packetSize-1:1]};
                    else
                        dOut <= {dOut[packetSize-2:0], dIn[0]};
                end
                SH_LOAD:  dOut <= dIn;
                SH_CLEAR: dOut <= '0;
                default:  dOut <= dOut;
            endcase
        end
    end

    packet_bit_counter #(
        .packetSize(packetSize)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (inc),
        .clr  (clr),
        .wrap (SIGNALGOT),
        .count(count)
    );

endmodule

// File: tb/tb_bit_stream_reg.sv
// Directed vector bench for bit_stream_reg with packetSize=4.
module tb_bit_stream_reg;

    localparam int N = 4;

    typedef struct {
        logic         rst;
        logic         ld;
        logic         msb;
        logic [1:0]   sh;
        logic [N-1:0] din;
        logic [N-1:0] exp_d;
        logic         exp_s;
        string        tag;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         LD = 1'b0;
    logic         msbLD = 1'b0;
    logic [1:0]   shift = 2'd0;
    logic [N-1:0] dIn = '0;
    logic [N-1:0] dOut;
    logic         SIGNALGOT;

    int applied = 0;
    int miscompares = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    bit_stream_reg #(.packetSize(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .LD       (LD),
        .msbLD    (msbLD),
        .shift    (shift),
        .dIn      (dIn),
        .dOut     (dOut),
        .SIGNALGOT(SIGNALGOT)
    );

    task automatic add(input logic r, input logic l, input logic m, input logic [1:0] s,
                       input logic [N-1:0] d, input logic [N-1:0] ed, input logic es,
                       input string t);
        vec_t v;
        v.rst = r; v.ld = l; v.msb = m; v.sh = s; v.din = d;
        v.exp_d = ed; v.exp_s = es; v.tag = t;
        vq.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; LD = v.ld; msbLD = v.msb; shift = v.sh; dIn = v.din;
        @(posedge clk);
        #1;
        applied++;
        if (dOut !== v.exp_d || SIGNALGOT !== v.exp_s) begin
            miscompares++;
            $display("FAIL %s: dOut=%b SIGNALGOT=%b, required dOut=%b SIGNALGOT=%b",
                     v.tag, dOut, SIGNALGOT, v.exp_d, v.exp_s);
        end
    endtask

    initial begin
        // reset, then LD=0 hold with arbitrary inputs
        add(1, 0, 0, 0, 4'b0000, 4'b0000, 0, "reset");
        for (int i = 0; i < 10; i++)
            add(0, 0, 1'($urandom), 2'($urandom), 4'($urandom), 4'b0000, 0, "ld0_hold");
        // continuous MSB-side shifting of ones, two packets
        add(0, 1, 1, 1, 4'b0001, 4'b1000, 0, "msb_ones1");
        add(0, 1, 1, 1, 4'b0001, 4'b1100, 0, "msb_ones2");
        add(0, 1, 1, 1, 4'b0001, 4'b1110, 0, "msb_ones3");
        add(0, 1, 1, 1, 4'b0001, 4'b1111, 1, "msb_ones4");
        add(0, 1, 1, 1, 4'b0001, 4'b1111, 0, "msb_ones5");
        add(0, 1, 1, 1, 4'b0001, 4'b1111, 0, "msb_ones6");
        add(0, 1, 1, 1, 4'b0001, 4'b1111, 0, "msb_ones7");
        add(0, 1, 1, 1, 4'b0001, 4'b1111, 1, "msb_ones8");
        // clear, then 1,0,1,0 via MSB then LSB insertion
        add(0, 1, 0, 3, 4'b1111, 4'b0000, 0, "clear_a");
        add(0, 1, 1, 1, 4'b0001, 4'b1000, 0, "msb_1010_a");
        add(0, 1, 1, 1, 4'b0000, 4'b0100, 0, "msb_1010_b");
        add(0, 1, 1, 1, 4'b0001, 4'b1010, 0, "msb_1010_c");
        add(0, 1, 1, 1, 4'b0000, 4'b0101, 1, "msb_1010_d");
        add(0, 1, 0, 1, 4'b0001, 4'b1011, 0, "lsb_1010_a");
        add(0, 1, 0, 1, 4'b0000, 4'b0110, 0, "lsb_1010_b");
        add(0, 1, 0, 1, 4'b0001, 4'b1101, 0, "lsb_1010_c");
        add(0, 1, 0, 1, 4'b0000, 4'b1010, 1, "lsb_1010_d");
        // two shifts, hold (shift=0 and LD=0), two shifts
        add(0, 1, 0, 1, 4'b0001, 4'b0101, 0, "pre_hold1");
        add(0, 1, 0, 1, 4'b0001, 4'b1011, 0, "pre_hold2");
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 0, 4'b1111, 4'b1011, 0, "hold_sh0");
        add(0, 0, 0, 1, 4'b0001, 4'b1011, 0, "hold_ld0a");
        add(0, 0, 1, 1, 4'b0001, 4'b1011, 0, "hold_ld0b");
        add(0, 1, 0, 1, 4'b0000, 4'b0110, 0, "post_hold1");
        add(0, 1, 0, 1, 4'b0000, 4'b1100, 1, "post_hold2");
        // partial count, parallel load discards it; upper dIn bits ignored on shift
        add(0, 1, 1, 1, 4'b1110, 4'b0110, 0, "pre_load1");
        add(0, 1, 1, 1, 4'b1110, 4'b0011, 0, "pre_load2");
        add(0, 1, 0, 2, 4'b1011, 4'b1011, 0, "load");
        add(0, 1, 1, 1, 4'b0001, 4'b1101, 0, "post_load1");
        add(0, 1, 1, 1, 4'b0001, 4'b1110, 0, "post_load2");
        add(0, 1, 1, 1, 4'b0001, 4'b1111, 0, "post_load3");
        add(0, 1, 1, 1, 4'b0001, 4'b1111, 1, "post_load4");
        add(0, 1, 0, 3, 4'b1011, 4'b0000, 0, "clear_b");

        foreach (vq[i]) apply(vq[i]);

        // mid-packet reset: three shifts, reset, then a fresh packet
        vq.delete();
        add(0, 1, 0, 1, 4'b0001, 4'b0001, 0, "pre_rst1");
        add(0, 1, 0, 1, 4'b0001, 4'b0011, 0, "pre_rst2");
        add(0, 1, 0, 1, 4'b0001, 4'b0111, 0, "pre_rst3");
        add(1, 1, 0, 1, 4'b0001, 4'b0000, 0, "mid_reset");
        add(0, 1, 0, 1, 4'b0001, 4'b0001, 0, "post_rst1");
        add(0, 1, 0, 1, 4'b0001, 4'b0011, 0, "post_rst2");
        add(0, 1, 0, 1, 4'b0001, 4'b0111, 0, "post_rst3");
        add(0, 1, 0, 1, 4'b0001, 4'b1111, 1, "post_rst4");
        add(0, 1, 0, 0, 4'b0000, 4'b1111, 0, "pulse_end");
        foreach (vq[i]) apply(vq[i]);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/bit_stream_reg.md
Name: bit_stream_reg

Overview:
Receive-side serial-to-parallel shift register for the UART receiver. It captures one serial bit per enabled clock into a packetSize-bit word. It can also hold, parallel-load or clear the word. It flags completion of each full packet with a one-cycle SIGNALGOT pulse, which the receiver FSM uses to latch the received data.

Parameters:
packetSize, 4, number of bits per received packet (word width of dIn/dOut); legal range 2..32

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
LD  input  1  register update enable; when 0 the register, counter and SIGNALGOT hold/clear as described below
msbLD  input  1  serial insertion side: 1 = new bit enters MSB (shift right, LSB-first UART), 0 = new bit enters LSB (shift left)
shift  input  2  operation select: 0 hold, 1 serial shift, 2 parallel load, 3 clear
dIn  input  packetSize  serial bit on dIn[0] for shift=1; full word for shift=2
dOut  output  packetSize  current register contents (registered)
SIGNALGOT  output  1  one-cycle pulse: a complete packet of packetSize serial bits is present on dOut

Behaviour:
- Reset (reset=1 at rising edge): dOut=0, bit counter=0, SIGNALGOT=0. Reset has priority over every other input.
- Operations are evaluated only when LD=1. With LD=0, dOut and the counter hold, and SIGNALGOT=0 next cycle.
- Operation table with LD=1, evaluated at the rising edge:
  - shift=0: hold dOut and the counter.
  - shift=1, msbLD=1: dOut <= {dIn[0], dOut[packetSize-1:1]}.
  - shift=1, msbLD=0: dOut <= {dOut[packetSize-2:0], dIn[0]}.
  - In both shift=1 cases the counter increments.
  - shift=2: dOut <= dIn; counter <= 0; no SIGNALGOT.
  - shift=3: dOut <= 0; counter <= 0.
- Counter:
  - Width $clog2(packetSize+1); counts serial shifts since the last reset, load, clear or packet completion.
  - The shift that makes the count equal packetSize sets the counter to 0 (wrap) and sets SIGNALGOT=1 on the same edge.
  - SIGNALGOT is therefore high during the cycle in which dOut first shows the complete packet.
- SIGNALGOT is registered and high for exactly one cycle per packet. During continuous shifting it pulses every packetSize cycles.
- dIn bits above bit 0 are ignored during shift=1.
- Latency: one clock from input to dOut/SIGNALGOT; no combinational path from inputs to outputs.
- msbLD may change between shifts; each shift uses the msbLD value present at that edge. Changing msbLD does not reset the counter.
- Mid-packet interruptions:
  - Reset, clear or parallel load mid-packet discards the partial count.
  - Holding (shift=0 or LD=0) preserves the partial count.

Decomposition:
- Shared package uart_pkg: enum shift_op_t {SH_HOLD=2'd0, SH_SERIAL=2'd1, SH_LOAD=2'd2, SH_CLEAR=2'd3}, plus default PACKET_SIZE constant.
- One natural sub-module: packet_bit_counter.
  - Inputs: clk, reset, inc, clr.
  - Outputs: wrap pulse, count.
  - Parameterised by packetSize.
  - Instantiated once, driving SIGNALGOT.

Test Plan:
1. Reset with packetSize=4 -> dOut=0000, SIGNALGOT=0; holds with LD=0 for 10 cycles regardless of dIn.
2. LD=1, shift=1, msbLD=1, dIn=1 for 4 cycles -> dOut 1000, 1100, 1110, 1111; SIGNALGOT=1 only in the 1111 cycle; continuing -> next pulse 4 cycles later.
3. msbLD=1, serial bits 1,0,1,0 (LSB first) -> dOut=0101 with a SIGNALGOT pulse; same bits with msbLD=0 -> dOut=1010 with a SIGNALGOT pulse.
4. Two shifts, then shift=0 for 5 cycles, then two shifts -> SIGNALGOT only after the 4th shift; dOut stable during hold.
5. shift=2, dIn=1011 -> dOut=1011, SIGNALGOT=0, counter cleared (next pulse after 4 more shifts); shift=3 -> dOut=0000.
6. Reset asserted after 3 shifts -> dOut=0000 and the next pulse requires 4 fresh shifts.
